tea_ctr_stream: RTL and testbench
=================================

Name: tea_ctr_stream

Overview:
Parametrised streaming successor to the single-shot TEA CTR block. It holds a key, nonce and counter loaded by one configuration strobe. It prefetches the keystream with an internal iterative TEA core and XORs a valid/ready input stream of 64-bit blocks into a registered output stream, advancing the counter once per block. It sits between the data DMA and the framing logic, with one configuration per message.

Parameters:
ROUNDS, 32, TEA cycles per block; one cycle per cycle; legal range 1..64.
CTR_W, 32, counter width; block word = {nonce[63-CTR_W:0], ctr}; legal range 8..64.
DELTA, 32'h9E3779B9, TEA round constant.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
cfg_load  in  1  one-cycle strobe: latch key/nonce/ctr_init, start a new message
key  in  128  k0=key[127:96] .. k3=key[31:0]
nonce  in  64-CTR_W  upper block bits
ctr_init  in  CTR_W  initial counter
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid&&in_ready
in_data  in  64  plaintext/ciphertext block
in_last  in  1  final block of message
out_valid  out  1  output beat valid
out_ready  in  1  downstream accept
out_data  out  64  in_data ^ keystream
out_last  out  1  copy of in_last for the beat
busy  out  1  message active (config loaded, last beat not yet delivered)
ctr_wrap  out  1  sticky: counter overflowed; cleared by cfg_load or reset

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs 0; state IDLE; key, nonce, counter and keystream registers cleared.
- States:
  - IDLE: in_ready=0. cfg_load -> GEN.
  - GEN: round count runs 0..ROUNDS-1, one TEA cycle per clk. v0=block[63:32], v1=block[31:0]. Each cycle: sum+=DELTA; v0+=((v1<<4)+k0)^(v1+sum)^((v1>>5)+k1); v1+=((v0'<<4)+k2)^(v0'+sum)^((v0'>>5)+k3). All arithmetic is mod 2^32. After ROUNDS cycles, keystream={v0,v1} and the state moves to READY.
  - READY: in_ready = !out_valid || out_ready.
  - On an input handshake:
    - out_data <= in_data^keystream, out_last <= in_last, out_valid <= 1 on the next edge.
    - The counter increments by 1.
    - If in_last=0, go to GEN with the new counter (prefetch). If in_last=1, go to DRAIN.
  - DRAIN: in_ready=0. When the output beat is taken (out_valid&&out_ready), go to IDLE and drop busy.
- Keystream latency: ROUNDS cycles from cfg_load or from the previous input handshake until in_ready can rise. in_ready is 0 throughout GEN.
- Output register:
  - Holds stable while out_valid&&!out_ready.
  - Cleared when out_valid&&out_ready, unless a new beat loads in the same cycle (back-to-back is allowed when in_ready is high).
- Counter wrap: an increment from all-ones sets ctr_wrap=1. The counter wraps to 0 but no further beats are accepted (in_ready=0). The state goes to DRAIN, then IDLE, once the pending output is taken.
- cfg_load in any non-IDLE state aborts the message:
  - Any in-flight generation is discarded and the pending out_valid is dropped.
  - ctr_wrap is cleared, new values are latched, and the state restarts in GEN.
  - in_ready is forced 0 in the cycle cfg_load is high; cfg_load wins over a simultaneous handshake.
- busy = 1 from the cycle after cfg_load until the cycle after the last output handshake or the wrap drain.
- in_valid while in_ready=0 has no effect; in_data is sampled only on a handshake.

Test Plan:
- Known vector: key=0, nonce=0, ctr_init=0, CTR_W=32, in_data=0, in_last=1 -> out_data=64'h41EA3A0A94BAA940, out_last=1. The first in_ready rises exactly 32 cycles after cfg_load. busy falls after the output handshake.
- Stream of 4 blocks, out_ready=1: out_data[i] equals the TEA of {nonce, ctr_init+i} XOR in_data[i] for i=0..3. in_ready is low for 32 cycles between beats.
- Backpressure: out_ready=0 for 50 cycles after beat 0 -> out_data stays stable. Beat 1 is not accepted while the output is still occupied; once the output is taken, beat 1 is accepted with no data lost.
- Wrap: CTR_W=8, ctr_init=8'hFF, two blocks offered -> the first is processed with ctr=FF, ctr_wrap=1, the second is never accepted, and the state returns to IDLE. A subsequent cfg_load clears ctr_wrap.
- Abort: cfg_load mid-GEN with a new key -> no output beat from the old key; the next output uses the new key and ctr_init.
- Reset: rst_n=0 asserted asynchronously mid-GEN and with out_valid=1 -> all outputs are 0 immediately, without waiting for a clock edge; the block stays IDLE until cfg_load.

Source files
------------

// File: rtl/tea_ctr_stream.sv
// Streaming TEA counter-mode block: latches key/nonce/counter on cfg_load and prefetches
// one keystream block per input beat with an iterative round engine, one round per clock.
module tea_ctr_stream #(
   parameter int unsigned ROUNDS = 32,
   parameter int unsigned CTR_W  = 32,
   parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_load,
   input  logic [127:0]      key,
   input  logic [63-CTR_W:0] nonce,
   input  logic [CTR_W-1:0]  ctr_init,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [63:0]       in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [63:0]       out_data,
   output logic              out_last,
   output logic              busy,
   output logic              ctr_wrap
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GEN   = 2'd1,
      S_READY = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t state, state_n;

   logic [127:0]      key_q;
   logic [63-CTR_W:0] nonce_q;
   logic [CTR_W-1:0]  ctr_q;
   logic [CTR_W-1:0]  ctr_inc;
   logic              ctr_max;

   logic [31:0] v0, v1, sum;
   logic [31:0] v0_n, v1_n, sum_n;
   logic [31:0] k0, k1, k2, k3;
   logic [6:0]  rnd;
   logic        last_round;

   logic [63:0] blk_cfg;
   logic [63:0] blk_next;

   logic hs;
   logic out_take;

   assign k0 = key_q[127:96];
   assign k1 = key_q[95:64];
   assign k2 = key_q[63:32];
   assign k3 = key_q[31:0];

   assign ctr_inc    = ctr_q + CTR_W'(1);
   assign ctr_max    = (ctr_q == {CTR_W{1'b1}});
   assign last_round = (rnd == 7'(ROUNDS - 1));
   assign out_take   = out_valid && out_ready;

   // At CTR_W=64 the nonce vector is degenerate; the cast keeps only the counter.
   assign blk_cfg  = 64'({nonce, ctr_init});
   assign blk_next = 64'({nonce_q, ctr_inc});

   // One full TEA round; v1 uses the freshly updated v0.
   always_comb begin
      sum_n = sum + DELTA;
      v0_n  = v0 + (((v1 << 4) + k0) ^ (v1 + sum_n) ^ ((v1 >> 5) + k1));
      v1_n  = v1 + (((v0_n << 4) + k2) ^ (v0_n + sum_n) ^ ((v0_n >> 5) + k3));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_n;
      end
   end

   // in_ready is only ever raised from READY, and cfg_load masks it so a new
   // configuration always wins over a same-cycle handshake.
   always_comb begin
      state_n  = state;
      in_ready = 1'b0;
      hs       = 1'b0;
      case (state)
         S_IDLE: begin
         end
         S_GEN: begin
            if (last_round) begin
               state_n = S_READY;
            end
         end
         S_READY: begin
            in_ready = !cfg_load && (!out_valid || out_ready);
            if (in_valid && in_ready) begin
               state_n = (in_last || ctr_max) ? S_DRAIN : S_GEN;
            end
         end
         S_DRAIN: begin
            if (out_take) begin
               state_n = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
      hs = in_valid && in_ready;
      if (cfg_load) begin
         state_n = S_GEN;
      end
   end

   // Configuration, counter and round engine. After the last round v0/v1 hold
   // the keystream until the next handshake reloads them with the next counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_q   <= '0;
         nonce_q <= '0;
         ctr_q   <= '0;
         v0      <= '0;
         v1      <= '0;
         sum     <= '0;
         rnd     <= '0;
      end else if (cfg_load) begin
         key_q   <= key;
         nonce_q <= nonce;
         ctr_q   <= ctr_init;
         v0      <= blk_cfg[63:32];
         v1      <= blk_cfg[31:0];
         sum     <= '0;
         rnd     <= '0;
      end else if (hs) begin
         ctr_q <= ctr_inc;
         v0    <= blk_next[63:32];
         v1    <= blk_next[31:0];
         sum   <= '0;
         rnd   <= '0;
      end else if (state == S_GEN) begin
         v0  <= v0_n;
         v1  <= v1_n;
         sum <= sum_n;
         rnd <= rnd + 7'd1;
      end
   end

   // Output register: a new beat may load in the same cycle the old one is taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else if (cfg_load) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else if (hs) begin
         out_valid <= 1'b1;
         out_data  <= in_data ^ {v0, v1};
         out_last  <= in_last;
      end else if (out_take) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy     <= 1'b0;
         ctr_wrap <= 1'b0;
      end else if (cfg_load) begin
         busy     <= 1'b1;
         ctr_wrap <= 1'b0;
      end else begin
         if (state == S_DRAIN && out_take) begin
            busy <= 1'b0;
         end
         if (hs && ctr_max) begin
            ctr_wrap <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_tea_ctr_stream.sv
// Bench for tea_ctr_stream: a 32-bit-counter and an 8-bit-counter instance share the
// stimulus (sel picks the active one); a transaction-level model predicts every cycle.
module tb_tea_ctr_stream;

   localparam int          ROUNDS = 32;
   localparam logic [31:0] DELTA  = 32'h9E3779B9;

   logic         clk;
   logic         rst_n;
   logic         sel;
   logic         cfg_load;
   logic [127:0] key;
   logic [63:0]  nonce64;
   logic [63:0]  ctr64;
   logic         in_valid;
   logic [63:0]  in_data;
   logic         in_last;
   logic         out_ready;

   logic        rdy32, ov32, ol32, busy32, wrap32;
   logic [63:0] od32;
   logic        rdy8, ov8, ol8, busy8, wrap8;
   logic [63:0] od8;

   logic        d_in_ready, d_out_valid, d_out_last, d_busy, d_ctr_wrap;
   logic [63:0] d_out_data;

   int   errors = 0;
   int   checks = 0;
   logic rnd_ready;
   logic got;
   int   waited;

   tea_ctr_stream #(.ROUNDS(ROUNDS), .CTR_W(32), .DELTA(DELTA)) dut32 (
      .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load & ~sel), .key(key),
      .nonce(nonce64[31:0]), .ctr_init(ctr64[31:0]),
      .in_valid(in_valid & ~sel), .in_ready(rdy32), .in_data(in_data), .in_last(in_last),
      .out_valid(ov32), .out_ready(out_ready | sel), .out_data(od32), .out_last(ol32),
      .busy(busy32), .ctr_wrap(wrap32)
   );

   tea_ctr_stream #(.ROUNDS(ROUNDS), .CTR_W(8), .DELTA(DELTA)) dut8 (
      .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load & sel), .key(key),
      .nonce(nonce64[55:0]), .ctr_init(ctr64[7:0]),
      .in_valid(in_valid & sel), .in_ready(rdy8), .in_data(in_data), .in_last(in_last),
      .out_valid(ov8), .out_ready(out_ready | ~sel), .out_data(od8), .out_last(ol8),
      .busy(busy8), .ctr_wrap(wrap8)
   );

   assign d_in_ready  = sel ? rdy8  : rdy32;
   assign d_out_valid = sel ? ov8   : ov32;
   assign d_out_data  = sel ? od8   : od32;
   assign d_out_last  = sel ? ol8   : ol32;
   assign d_busy      = sel ? busy8 : busy32;
   assign d_ctr_wrap  = sel ? wrap8 : wrap32;

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [63:0] tea_enc(input logic [127:0] k, input logic [63:0] blk);
      logic [31:0] y, z, s;
      y = blk[63:32];
      z = blk[31:0];
      s = 32'h0;
      for (int r = 0; r < ROUNDS; r++) begin
         s = s + DELTA;
         y = y + (((z << 4) + k[127:96]) ^ (z + s) ^ ((z >> 5) + k[95:64]));
         z = z + (((y << 4) + k[63:32]) ^ (y + s) ^ ((y >> 5) + k[31:0]));
      end
      return {y, z};
   endfunction

   function automatic int ctr_w();
      return sel ? 8 : 32;
   endfunction

   function automatic logic [63:0] ctr_mask();
      return sel ? 64'hFF : 64'hFFFF_FFFF;
   endfunction

   logic         m_busy, m_done, m_wrap, m_ov;
   int           m_gen_left;
   logic [127:0] m_key;
   logic [63:0]  m_nonce, m_ctr;
   logic [64:0]  exp_q[$];

   // Input is accepted only once the keystream is ready, the message still takes
   // beats, the output slot is free (or being freed) and no reconfiguration is in flight.
   function automatic logic model_in_ready();
      return !cfg_load && m_busy && !m_done && (m_gen_left == 0) && (!m_ov || out_ready);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 1'b0; m_done <= 1'b0; m_wrap <= 1'b0; m_ov <= 1'b0;
         m_gen_left <= 0; m_key <= '0; m_nonce <= '0; m_ctr <= '0;
         exp_q.delete();
      end else if (cfg_load) begin
         m_busy <= 1'b1; m_done <= 1'b0; m_wrap <= 1'b0; m_ov <= 1'b0;
         m_gen_left <= ROUNDS; m_key <= key; m_nonce <= nonce64; m_ctr <= ctr64 & ctr_mask();
         exp_q.delete();
      end else if (in_valid && model_in_ready()) begin
         exp_q.push_back({in_last, in_data ^ tea_enc(m_key, (m_nonce << ctr_w()) | m_ctr)});
         m_ov  <= 1'b1;
         m_ctr <= (m_ctr + 64'd1) & ctr_mask();
         if (m_ctr == ctr_mask()) begin
            m_wrap <= 1'b1;
            m_done <= 1'b1;
         end else if (in_last) begin
            m_done <= 1'b1;
         end else begin
            m_gen_left <= ROUNDS;
         end
      end else begin
         if (m_gen_left != 0) m_gen_left <= m_gen_left - 1;
         if (m_ov && out_ready) begin
            m_ov <= 1'b0;
            if (m_done) m_busy <= 1'b0;
         end
      end
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      check("in_ready", 64'(d_in_ready), 64'(model_in_ready()));
      check("out_valid", 64'(d_out_valid), 64'(m_ov));
      check("busy", 64'(d_busy), 64'(m_busy));
      check("ctr_wrap", 64'(d_ctr_wrap), 64'(m_wrap));
      if (d_out_valid) begin
         check("beats_pending", 64'(exp_q.size()), 64'd1);
         if (exp_q.size() > 0) begin
            check("out_data", d_out_data, exp_q[0][63:0]);
            check("out_last", 64'(d_out_last), 64'(exp_q[0][64]));
            if (out_ready) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      end
   end

   // ---------------- driver tasks (entered and left at posedge+1) ----------------
   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_cfg(input logic [127:0] k, input logic [63:0] n, input logic [63:0] c);
      key = k; nonce64 = n; ctr64 = c; cfg_load = 1'b1;
      @(posedge clk);
      #1;
      cfg_load = 1'b0;
   endtask

   task automatic send_block(input logic [63:0] d, input logic l, input int max_cyc,
                             output logic ok, output int w);
      in_valid = 1'b1; in_data = d; in_last = l;
      ok = 1'b0; w = 0;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk);
         if (d_in_ready) begin
            ok = 1'b1;
            w = i;
         end
         @(posedge clk);
         #1;
         if (ok) break;
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_idle(input int max_cyc);
      logic done;
      done = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk);
         done = !d_busy;
         @(posedge clk);
         #1;
         if (done) break;
      end
      check("idle_reached", 64'(done), 64'd1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_in_ready"}, 64'(d_in_ready), 64'd0);
      check({tag, "_out_valid"}, 64'(d_out_valid), 64'd0);
      check({tag, "_out_data"}, d_out_data, 64'd0);
      check({tag, "_out_last"}, 64'(d_out_last), 64'd0);
      check({tag, "_busy"}, 64'(d_busy), 64'd0);
      check({tag, "_ctr_wrap"}, 64'(d_ctr_wrap), 64'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int nblk;
      logic [63:0] start;
      rst_n = 1'b0; sel = 1'b0; cfg_load = 1'b0; key = '0; nonce64 = '0; ctr64 = '0;
      in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1; rnd_ready = 1'b0;
      #12 rst_n = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      check_all_zero("reset");
      check("model_kat", tea_enc(128'h0, 64'h0), 64'h41EA3A0A94BAA940);
      @(posedge clk);
      #1;

      // known vector
      do_cfg(128'h0, 64'h0, 64'h0);
      send_block(64'h0, 1'b1, 100, got, waited);
      check("kat_accepted", 64'(got), 64'd1);
      check("kat_ready_latency", 64'(waited), 64'd32);
      @(negedge clk);
      check("kat_out_data", d_out_data, 64'h41EA3A0A94BAA940);
      check("kat_out_last", 64'(d_out_last), 64'd1);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("kat_busy_drop", 64'(d_busy), 64'd0);
      @(posedge clk);
      #1;

      // four-block stream, free-running output
      do_cfg({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom}, {32'h0, $urandom});
      for (int b = 0; b < 4; b++) begin
         send_block({$urandom, $urandom}, 1'(b == 3), 100, got, waited);
         check("stream_gap", 64'(waited), 64'd32);
      end
      wait_idle(100);

      // backpressure: output held for 50 cycles, next beat waits for the slot
      out_ready = 1'b0;
      do_cfg({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom}, {32'h0, $urandom});
      send_block({$urandom, $urandom}, 1'b0, 100, got, waited);
      fork
         send_block({$urandom, $urandom}, 1'b0, 200, got, waited);
         begin
            wait_cycles(50);
            out_ready = 1'b1;
         end
      join
      check("bp_beat1_accepted", 64'(got), 64'd1);
      send_block({$urandom, $urandom}, 1'b1, 100, got, waited);
      wait_idle(100);

      // counter wrap on the 8-bit instance
      sel = 1'b1;
      do_cfg({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom}, 64'hFF);
      send_block({$urandom, $urandom}, 1'b0, 100, got, waited);
      check("wrap_first_accepted", 64'(got), 64'd1);
      send_block({$urandom, $urandom}, 1'b0, 60, got, waited);
      check("wrap_second_refused", 64'(got), 64'd0);
      check("wrap_sticky", 64'(d_ctr_wrap), 64'd1);
      check("wrap_idle", 64'(d_busy), 64'd0);
      do_cfg({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom}, 64'h10);
      @(negedge clk);
      check("wrap_cleared", 64'(d_ctr_wrap), 64'd0);
      @(posedge clk);
      #1;
      send_block({$urandom, $urandom}, 1'b1, 100, got, waited);
      wait_idle(100);
      sel = 1'b0;

      // abort mid-GEN, then abort with an output beat still pending
      do_cfg({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom}, {32'h0, $urandom});
      wait_cycles(10);
      do_cfg({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom}, {32'h0, $urandom});
      send_block({$urandom, $urandom}, 1'b1, 100, got, waited);
      check("abort_new_gen_latency", 64'(waited), 64'd32);
      wait_idle(100);
      out_ready = 1'b0;
      do_cfg({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom}, {32'h0, $urandom});
      send_block({$urandom, $urandom}, 1'b0, 100, got, waited);
      wait_cycles(5);
      do_cfg({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom}, {32'h0, $urandom});
      out_ready = 1'b1;
      send_block({$urandom, $urandom}, 1'b1, 100, got, waited);
      wait_idle(100);

      // randomized messages with random downstream readiness
      for (int m = 0; m < 12; m++) begin
         rnd_ready = 1'b1;
         start = (m % 4 == 3) ? 64'hFFFF_FFFE : {32'h0, $urandom};
         do_cfg({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom}, start);
         nblk = $urandom_range(1, 4);
         if (m % 5 == 2) begin
            wait_cycles($urandom_range(1, 60));
            do_cfg({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom}, start);
         end
         for (int b = 0; b < nblk; b++) begin
            send_block({$urandom, $urandom}, 1'(b == nblk - 1), 150, got, waited);
            if (!got) break;
         end
         wait_idle(400);
      end
      rnd_ready = 1'b0;
      out_ready = 1'b1;

      // asynchronous reset mid-GEN, then with an output beat pending
      do_cfg({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom}, {32'h0, $urandom});
      wait_cycles(10);
      #2 rst_n = 1'b0;
      #1 check_all_zero("rst_gen");
      @(posedge clk);
      #1 rst_n = 1'b1;
      out_ready = 1'b0;
      do_cfg({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom}, {32'h0, $urandom});
      send_block({$urandom, $urandom}, 1'b0, 100, got, waited);
      wait_cycles(3);
      check("rst_pre_out_valid", 64'(d_out_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1 check_all_zero("rst_out");
      @(posedge clk);
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      send_block({$urandom, $urandom}, 1'b1, 40, got, waited);
      check("rst_stays_idle", 64'(got), 64'd0);
      do_cfg({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom}, {32'h0, $urandom});
      send_block({$urandom, $urandom}, 1'b1, 100, got, waited);
      check("post_reset_accept", 64'(got), 64'd1);
      wait_idle(100);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
